// File: rtl/reg_dump.sv
// Dumps a contiguous range of register-file entries as a valid/ready word stream.
// Keeps a running XOR checksum of every word the consumer accepts.
module reg_dump #(
    parameter logic [3:0] FIRST_REG = 4'd0,
    parameter logic [3:0] LAST_REG  = 4'd15
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_abort,
    output logic [3:0]  o_rd_reg,
    input  logic [15:0] i_rd_data,
    output logic        o_out_valid,
    input  logic        i_out_ready,
    output logic [15:0] o_out_data,
    output logic [3:0]  o_out_index,
    output logic        o_out_last,
    output logic        o_busy,
    output logic        o_done,
    output logic [15:0] o_checksum
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // An inverted range produces an empty dump that completes immediately.
    localparam logic EMPTY_RANGE = (FIRST_REG > LAST_REG);

    logic [1:0]  r_state;
    logic [3:0]  r_index;
    logic [15:0] r_out_data;
    logic [3:0]  r_out_index;
    logic        r_out_last;
    logic [15:0] r_checksum;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_index     <= FIRST_REG;
            r_out_data  <= 16'h0000;
            r_out_index <= 4'd0;
            r_out_last  <= 1'b0;
            r_checksum  <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start && !i_abort) begin
                        r_index    <= FIRST_REG;
                        r_checksum <= 16'h0000;
                        r_state    <= EMPTY_RANGE ? S_DONE : S_READ;
                    end
                end
                S_READ: begin
                    if (i_abort) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_out_data  <= i_rd_data;
                        r_out_index <= r_index;
                        r_out_last  <= (r_index == LAST_REG);
                        r_state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    // A word handed over in the abort cycle still counts toward the checksum.
                    if (i_out_ready) begin
                        r_checksum <= r_checksum ^ r_out_data;
                        if (i_abort) begin
                            r_state <= S_IDLE;
                        end else if (r_out_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_index <= r_index + 4'd1;
                            r_state <= S_READ;
                        end
                    end else if (i_abort) begin
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_rd_reg    = r_index;
    assign o_out_valid = (r_state == S_SEND);
    assign o_out_data  = r_out_data;
    assign o_out_index = r_out_index;
    assign o_out_last  = r_out_last;
    assign o_busy      = (r_state == S_READ) || (r_state == S_SEND);
    assign o_done      = (r_state == S_DONE);
    assign o_checksum  = r_checksum;

endmodule
